// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM states, the NOP word and
// the opcode field used to recognise the halt instruction.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
    localparam logic [5:0]  HALT_OP_DEFAULT = 6'h3F;
    localparam int          OPCODE_HI       = 31;
    localparam int          OPCODE_LO       = 26;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures an instruction and its pc+1, or holds,
// or collapses to a NOP bubble. A bubble takes priority over a hold.
module if_id_register
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic              hold,
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] pc_plus1,
    output logic [31:0]       if_id_instruction,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            if_id_instruction <= NOP_WORD;
            if_id_pc_plus1    <= '0;
            if_id_valid       <= 1'b0;
        end else if (!hold) begin
            if_id_instruction <= instruction;
            if_id_pc_plus1    <= pc_plus1;
            if_id_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, the BOOT/RUN/HALT state machine and
// the saturating fetched-instruction counter; feeds the IF/ID register.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = HALT_OP_DEFAULT,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] instruction_address,
    input  logic [31:0]       instruction,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [31:0]       if_id_instruction,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              bubble;
    logic              is_halt_word;

    assign instruction_address = pc;
    assign pc_plus1            = pc + 1'b1;
    assign is_halt_word        = (opcode_of(instruction) == HALT_OP);

    // Only RUN captures; BOOT, HALT and any redirect flush IF/ID to a NOP.
    assign bubble = (state != RUN) || branch_taken;

    if_id_register #(
        .ADDR_W(ADDR_W)
    ) u_if_id (
        .clk              (clk),
        .rst_n            (rst_n),
        .bubble           (bubble),
        .hold             (stall),
        .instruction      (instruction),
        .pc_plus1         (pc_plus1),
        .if_id_instruction(if_id_instruction),
        .if_id_pc_plus1   (if_id_pc_plus1),
        .if_id_valid      (if_id_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            state       <= BOOT;
            fetch_count <= '0;
            halted      <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                    end else if (!stall) begin
                        pc <= pc_plus1;
                        if (fetch_count != '1)
                            fetch_count <= fetch_count + 1'b1;
                        if (is_halt_word) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    // A redirect while halted means the halt word was wrong-path.
                    if (branch_taken) begin
                        pc     <= branch_target;
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table from
// the fetch scenarios, then randomized traffic against a behavioural model.
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 6;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] instruction_address;
    logic [31:0]       instruction;
    logic              stall = 1'b0;
    logic              branch_taken = 1'b0;
    logic [ADDR_W-1:0] branch_target = '0;
    logic [31:0]       if_id_instruction;
    logic [ADDR_W-1:0] if_id_pc_plus1;
    logic              if_id_valid;
    logic              halted;
    logic [CNT_W-1:0]  fetch_count;

    logic [31:0] mem [DEPTH];
    assign instruction = mem[instruction_address];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC('0),
        .HALT_OP (6'h3F),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instruction_address(instruction_address),
        .instruction        (instruction),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .if_id_instruction  (if_id_instruction),
        .if_id_pc_plus1     (if_id_pc_plus1),
        .if_id_valid        (if_id_valid),
        .halted             (halted),
        .fetch_count        (fetch_count)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch stage should hold after each edge.
    int  m_pc = 0, m_pc1 = 0, m_count = 0;
    bit  m_boot = 1'b1, m_halted = 1'b0, m_valid = 1'b0;
    logic [31:0] m_ir = 32'h0;

    task automatic model_step(input bit rst, input bit stl, input bit br, input int tgt);
        logic [31:0] word;
        if (!rst) begin
            m_pc = 0; m_boot = 1; m_halted = 0;
            m_ir = 0; m_pc1 = 0; m_valid = 0; m_count = 0;
        end else if (m_boot) begin
            m_boot = 0;
            m_ir = 0; m_pc1 = 0; m_valid = 0;
        end else if (m_halted || br) begin
            if (br) begin
                m_pc = tgt;
                m_halted = 0;
            end
            m_ir = 0; m_pc1 = 0; m_valid = 0;
        end else if (!stl) begin
            word    = mem[m_pc];
            m_ir    = word;
            m_pc    = (m_pc + 1) % DEPTH;
            m_pc1   = m_pc;
            m_valid = 1;
            m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
            if (word[31:26] == 6'h3F) m_halted = 1;
        end
    endtask

    // Drive inputs away from the edge, clock once, advance the model, settle.
    task automatic cycle(input bit rst, input bit stl, input bit br, input int tgt);
        rst_n = rst; stall = stl; branch_taken = br; branch_target = tgt[ADDR_W-1:0];
        @(posedge clk);
        model_step(rst, stl, br, tgt);
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          stl;
        bit          br;
        int          tgt;
        int          addr;
        logic [31:0] ir;
        int          pc1;
        bit          valid;
        bit          hlt;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h1000 + k;
        mem[5] = 32'hFC00_0000;

        //          rst stl br tgt  addr ir            pc1 v  h  cnt
        vecs.push_back('{0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 0});  // reset
        vecs.push_back('{1, 0, 0, 0,  0, 32'h0,        0, 0, 0, 0});  // boot
        vecs.push_back('{1, 0, 0, 0,  1, 32'h1000,     1, 1, 0, 1});
        vecs.push_back('{1, 0, 0, 0,  2, 32'h1001,     2, 1, 0, 2});
        vecs.push_back('{1, 0, 0, 0,  3, 32'h1002,     3, 1, 0, 3});
        vecs.push_back('{1, 0, 0, 0,  4, 32'h1003,     4, 1, 0, 4});
        vecs.push_back('{1, 1, 0, 0,  4, 32'h1003,     4, 1, 0, 4});  // stall
        vecs.push_back('{1, 1, 0, 0,  4, 32'h1003,     4, 1, 0, 4});  // stall
        vecs.push_back('{1, 0, 0, 0,  5, 32'h1004,     5, 1, 0, 5});
        vecs.push_back('{1, 0, 0, 0,  6, 32'hFC000000, 6, 1, 1, 6});  // halt word
        vecs.push_back('{1, 0, 0, 0,  6, 32'h0,        0, 0, 1, 6});
        vecs.push_back('{1, 1, 0, 0,  6, 32'h0,        0, 0, 1, 6});  // stall ignored
        vecs.push_back('{1, 0, 1, 2,  2, 32'h0,        0, 0, 0, 6});  // unhalt
        vecs.push_back('{1, 0, 0, 0,  3, 32'h1002,     3, 1, 0, 7});
        vecs.push_back('{1, 1, 1, 20, 20, 32'h0,       0, 0, 0, 7});  // redirect beats stall
        vecs.push_back('{1, 0, 0, 0, 21, 32'h1014,    21, 1, 0, 8});
        vecs.push_back('{1, 0, 1, 63, 63, 32'h0,       0, 0, 0, 8});
        vecs.push_back('{1, 0, 0, 0,  0, 32'h103F,     0, 1, 0, 9});  // wrap
        vecs.push_back('{1, 0, 0, 0,  1, 32'h1000,     1, 1, 0, 10});
        vecs.push_back('{1, 0, 1, 9,  9, 32'h0,        0, 0, 0, 10});
        vecs.push_back('{0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 0});  // mid-run reset
        vecs.push_back('{1, 1, 1, 33, 0, 32'h0,        0, 0, 0, 0});  // boot ignores inputs
        vecs.push_back('{1, 0, 0, 0,  1, 32'h1000,     1, 1, 0, 1});

        @(negedge clk);
        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt);
            check($sformatf("v%0d addr", i), 32'(instruction_address), 32'(vecs[i].addr));
            check($sformatf("v%0d ir", i), if_id_instruction, vecs[i].ir);
            check($sformatf("v%0d pc1", i), 32'(if_id_pc_plus1), 32'(vecs[i].pc1));
            check($sformatf("v%0d valid", i), 32'(if_id_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].hlt));
            check($sformatf("v%0d count", i), 32'(fetch_count), 32'(vecs[i].cnt));
        end

        // Stall held at pc=1: address stays put across several edges.
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 0);
            check("stall addr", 32'(instruction_address), 32'd1);
            check("stall ir", if_id_instruction, 32'h1000);
        end

        // Counter saturation: long straight run from pc=1 with no halt words.
        mem[5] = 32'h1005;
        for (int k = 0; k < 20; k++) cycle(1, 0, 0, 0);
        check("count saturated", 32'(fetch_count), CMAX);
        cycle(1, 0, 0, 0);
        check("count stays saturated", 32'(fetch_count), CMAX);

        // Randomized traffic with sparse halt words.
        for (int k = 0; k < DEPTH; k++)
            mem[k] = ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)} : $urandom;
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, DEPTH - 1)));
            check("rnd addr", 32'(instruction_address), 32'(m_pc));
            check("rnd ir", if_id_instruction, m_ir);
            check("rnd pc1", 32'(if_id_pc_plus1), 32'(m_pc1));
            check("rnd valid", 32'(if_id_valid), 32'(m_valid));
            check("rnd halted", 32'(halted), 32'(m_halted));
            check("rnd count", 32'(fetch_count), 32'(m_count));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the five-stage MIPS pipeline, acting as the initiator toward the instruction memory.
- Holds the program counter and drives a word address to the instruction memory, which responds combinationally in the same cycle.
- Registers the returned instruction into the IF/ID pipeline register.
- Handles stall, branch redirect with a bubble, and a halt state machine.

Parameters:
- ADDR_W, 6, word-address width; PC and address wrap modulo 2^ADDR_W.
- RESET_PC, 0, word address loaded on reset.
- HALT_OP, 6'h3F, opcode (bits 31:26) that halts fetch.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- instruction_address  out  ADDR_W  word address to instruction memory; always equals pc.
- instruction  in  32  memory response for instruction_address, valid the same cycle.
- stall  in  1  hazard unit: hold pc and IF/ID.
- branch_taken  in  1  redirect request from ID/EX.
- branch_target  in  ADDR_W  word address to redirect to.
- if_id_instruction  out  32  registered instruction; 0 (NOP) when bubble.
- if_id_pc_plus1  out  ADDR_W  registered pc+1 of the captured instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  state==HALT.
- fetch_count  out  CNT_W  number of instructions captured with valid=1; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_PC, state=BOOT.
  - if_id_instruction=0, if_id_pc_plus1=0, if_id_valid=0, fetch_count=0, halted=0.
  - Reset mid-operation discards all in-flight state the same edge.
- States: BOOT, RUN, HALT.
- BOOT:
  - One cycle only.
  - No capture: IF/ID stays a bubble, pc holds.
  - Next state is RUN unconditionally. stall and branch_taken are ignored in BOOT.
- RUN, per edge, in priority order:
  1. branch_taken=1:
     - pc<=branch_target.
     - IF/ID<=bubble (instruction 0, valid 0, pc_plus1 0).
     - Stays RUN. Redirect beats stall.
  2. stall=1: pc, IF/ID, fetch_count all hold.
  3. Otherwise:
     - if_id_instruction<=instruction, if_id_pc_plus1<=pc+1 (mod 2^ADDR_W), if_id_valid<=1.
     - pc<=pc+1 (mod 2^ADDR_W).
     - fetch_count increments, saturating.
     - If instruction[31:26]==HALT_OP: the halt word is still captured valid, pc still advances, state<=HALT.
- HALT:
  - pc holds, IF/ID<=bubble each edge, halted=1.
  - branch_taken=1 means the halt was wrong-path: pc<=branch_target, IF/ID bubble, state<=RUN, halted drops the next cycle.
  - stall is ignored in HALT.
- Latency: the instruction at address A appears in IF/ID one edge after pc==A with no stall or redirect.
- Wrap-around: pc=2^ADDR_W-1 advances to 0; its if_id_pc_plus1 is 0.
- instruction_address is a purely combinational copy of pc, with no added latency.

Decomposition:
- Shared package (mips_pkg):
  - FETCH_STATE enum: BOOT, RUN, HALT.
  - NOP word constant 32'h0.
  - HALT_OP default.
  - Opcode field bounds 31:26.
- Natural sub-module: if_id_register, holding the instruction/pc_plus1/valid capture with hold and bubble controls.
- PC, state machine and counter stay in the top.

Test Plan:
- Memory model returns word k = 0x1000+k.
- Reset then free run: IF/ID is a bubble in BOOT; the next edges capture 0x1000, 0x1001, 0x1002 with pc_plus1 1, 2, 3 and valid=1; fetch_count=3.
- Stall for 2 cycles while pc=4: instruction_address stays 4, IF/ID holds 0x1003, fetch_count unchanged; after release, 0x1004 is captured.
- branch_taken with branch_target=20 and stall=1 on the same edge: pc=20, IF/ID bubble (0, valid 0); the next edge captures 0x1014.
- Word 5 = 32'hFC00_0000 (opcode 3F): captured valid, halted=1 the next cycle, pc=6 frozen, bubbles follow; branch_taken to 2 → halted=0, next capture 0x1002.
- pc=63 (ADDR_W=6): capture 0x103F with pc_plus1=0, then instruction_address=0 and capture 0x1000.
- rst_n low for one edge mid-run at pc=9: all outputs are zero and pc=0, BOOT for one cycle, then capture 0x1000.
